// File: rtl/if_id_queue_if.sv
// if_id_queue_if
//   Fetch-to-decode handshake bundle for the IF/ID queue.
//   Fetch side : in_valid, in_ready, in_pc, in_instr
//   Decode side: out_valid, out_ready, out_pc, out_instr
//   slave  : the queue's view (accepts from fetch, presents to decode)
//   master : the environment's view (fetch producer + decode consumer)
interface if_id_queue_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue
//   Decoupling queue between fetch and decode. Holds up to DEPTH
//   {PC, instruction} pairs in a circular buffer. Decode sees a NOP bubble
//   (out_pc = 0, out_instr = NOP_INSTR) whenever the queue is empty.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : fetch/decode valid-ready handshake (if_id_queue_if.slave)
//   flush  : synchronous discard of all entries (redirect)
//   count  : current occupancy, 0..DEPTH
module if_id_queue #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                 CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  if_id_queue_if.slave      bus,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready/valid derive only from registered occupancy: no out_ready -> in_ready path.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & bus.out_ready;

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_pc    = w_empty ? '0        : r_mem_pc[r_rd_ptr];
  assign bus.out_instr = w_empty ? NOP_INSTR : r_mem_instr[r_rd_ptr];
  assign count         = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_pc[r_wr_ptr]    <= bus.in_pc;
      r_mem_instr[r_wr_ptr] <= bus.in_instr;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush4, flush3;
  logic [2:0] count4;
  logic [1:0] count3;

  always #5 clk = ~clk;

  if_id_queue_if #(.PC_W(64), .INSTR_W(32)) bus4 ();
  if_id_queue_if #(.PC_W(64), .INSTR_W(32)) bus3 ();

  if_id_queue #(.DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4), .flush(flush4), .count(count4));
  if_id_queue #(.DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3), .flush(flush3), .count(count3));

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } pair_t;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        rdy;
    logic        exp_rdy;
    logic        exp_val;
    int          exp_cnt;
  } vec_t;

  pair_t q4[$];
  pair_t q3[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return 32'hC0DE_0000 ^ pc[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the negedge, check against the queue model
  // just before the rising edge, then advance the model by that edge's effect.
  task automatic step4(input logic v, input logic [63:0] pc, input logic rdy, input logic fl,
                       output logic acc);
    logic  er, ev;
    pair_t p;
    bus4.in_valid = v; bus4.in_pc = pc; bus4.in_instr = ins_of(pc);
    bus4.out_ready = rdy; flush4 = fl;
    #1;
    er = (q4.size() != 4);
    ev = (q4.size() != 0);
    chk("q4_in_ready", bus4.in_ready, er);
    chk("q4_out_valid", bus4.out_valid, ev);
    chk("q4_count", count4, 64'(q4.size()));
    if (ev) begin
      chk("q4_head_pc", bus4.out_pc, q4[0].pc);
      chk("q4_head_instr", bus4.out_instr, q4[0].instr);
    end else begin
      chk("q4_empty_pc", bus4.out_pc, 0);
      chk("q4_empty_instr", bus4.out_instr, NOP);
    end
    acc = v & er & ~fl;
    if (fl) q4.delete();
    else begin
      if (ev && rdy) void'(q4.pop_front());
      if (v && er) begin p.pc = pc; p.instr = ins_of(pc); q4.push_back(p); end
    end
  endtask

  task automatic step3(input logic v, input logic [63:0] pc, input logic rdy, output logic acc);
    logic  er, ev;
    pair_t p;
    bus3.in_valid = v; bus3.in_pc = pc; bus3.in_instr = ins_of(pc);
    bus3.out_ready = rdy; flush3 = 1'b0;
    #1;
    er = (q3.size() != 3);
    ev = (q3.size() != 0);
    chk("q3_in_ready", bus3.in_ready, er);
    chk("q3_out_valid", bus3.out_valid, ev);
    chk("q3_count", count3, 64'(q3.size()));
    if (ev) begin
      chk("q3_head_pc", bus3.out_pc, q3[0].pc);
      chk("q3_head_instr", bus3.out_instr, q3[0].instr);
    end else begin
      chk("q3_empty_instr", bus3.out_instr, NOP);
    end
    acc = v & er;
    if (ev && rdy) void'(q3.pop_front());
    if (v && er) begin p.pc = pc; p.instr = ins_of(pc); q3.push_back(p); end
  endtask

  vec_t tbl[14];
  logic acc;
  logic [63:0] pc3;
  logic v3s   [13] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  logic rdy3s [13] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    //             v  pc        rdy  rdy val cnt
    tbl[0]  = '{1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 64'h104, 1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{1'b1, 64'h108, 1'b0, 1'b1, 1'b1, 2};
    tbl[3]  = '{1'b1, 64'h10C, 1'b0, 1'b1, 1'b1, 3};
    tbl[4]  = '{1'b1, 64'h110, 1'b0, 1'b0, 1'b1, 4};
    tbl[5]  = '{1'b1, 64'h110, 1'b1, 1'b0, 1'b1, 4};
    tbl[6]  = '{1'b1, 64'h110, 1'b1, 1'b1, 1'b1, 3};
    tbl[7]  = '{1'b1, 64'h114, 1'b1, 1'b1, 1'b1, 3};
    tbl[8]  = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 3};
    tbl[9]  = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 2};
    tbl[10] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 0};
    tbl[13] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 0};

    reset = 1'b0;
    flush4 = 1'b0; flush3 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_pc = '0; bus4.in_instr = '0; bus4.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_pc = '0; bus3.in_instr = '0; bus3.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus4.out_valid, 0);
    chk("rst_out_instr", bus4.out_instr, NOP);
    chk("rst_out_pc", bus4.out_pc, 0);
    chk("rst_in_ready", bus4.in_ready, 1);
    chk("rst_count", count4, 0);
    chk("rst_count3", count3, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fill/stall, drain, then an empty queue with out_ready toggling.
    for (int i = 0; i < 14; i++) begin
      step4(tbl[i].v, tbl[i].pc, tbl[i].rdy, 1'b0, acc);
      chk($sformatf("tbl%0d_in_ready", i), bus4.in_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_out_valid", i), bus4.out_valid, tbl[i].exp_val);
      chk($sformatf("tbl%0d_count", i), count4, 64'(tbl[i].exp_cnt));
      @(negedge clk);
    end

    // Streaming at one pair per cycle.
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, 64'(i * 4), 1'b1, 1'b0, acc);
      @(negedge clk);
      chk("stream_count", count4, 1);
    end
    step4(1'b0, 64'h0, 1'b1, 1'b0, acc);
    @(negedge clk);

    // Flush with simultaneous push and pop at count 2.
    step4(1'b1, 64'h200, 1'b0, 1'b0, acc); @(negedge clk);
    step4(1'b1, 64'h204, 1'b0, 1'b0, acc); @(negedge clk);
    step4(1'b1, 64'h208, 1'b1, 1'b1, acc); @(negedge clk);
    step4(1'b0, 64'h0, 1'b1, 1'b0, acc);
    chk("flush_count", count4, 0);
    chk("flush_instr", bus4.out_instr, NOP);
    @(negedge clk);

    // Asynchronous reset mid-stream with 3 entries held.
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 64'h300 + 64'(i * 4), 1'b0, 1'b0, acc);
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus4.out_valid, 0);
    chk("mid_rst_out_instr", bus4.out_instr, NOP);
    chk("mid_rst_count", count4, 0);
    q4.delete();
    q3.delete();
    @(negedge clk);
    reset = 1'b1;
    step4(1'b1, 64'hA00, 1'b0, 1'b0, acc); @(negedge clk);
    step4(1'b1, 64'hA04, 1'b0, 1'b0, acc); @(negedge clk);
    chk("post_rst_head", bus4.out_pc, 64'hA00);
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 64'h0, 1'b1, 1'b0, acc);
      @(negedge clk);
    end

    // DEPTH=3 wrap-around with occupancy oscillating between 1 and 3.
    pc3 = 64'h1000;
    for (int i = 0; i < 13; i++) begin
      step3(v3s[i], pc3, rdy3s[i], acc);
      if (acc) pc3 = pc3 + 64'h4;
      @(negedge clk);
    end
    step3(1'b0, 64'h0, 1'b1, acc);
    chk("wrap_total_pushed", pc3, 64'h1000 + 64'h4 * 9);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID decoupling queue that replaces the single-entry fetch/decode pipeline register. It buffers up to DEPTH fetched {PC, instruction} pairs between fetch and decode. Transfers use a valid/ready handshake instead of a bare write-enable, and flush is synchronous for branch/jump redirects. When empty, decode sees a canonical NOP bubble, so hazard logic upstream only has to deassert ready.

## Interface
Parameters:
- PC_W, 64, PC width
- INSTR_W, 32, instruction width
- DEPTH, 4, number of entries; legal range 2..16, not required to be a power of two
- NOP_INSTR, 32'h0000_0013, instruction driven on out_instr while out_valid=0 (addi x0,x0,0)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a valid pair
- in_ready  out  1  queue can accept a pair this cycle
- in_pc  in  PC_W  PC of the fetched instruction
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode consumes the head this cycle (deasserted for load-use stall)
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction, or NOP_INSTR when empty
- flush  in  1  discard all entries (branch taken / redirect)
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries with read pointer rd_ptr, write pointer wr_ptr and occupancy count. Pointers wrap from DEPTH-1 to 0 by compare, not by modulo-2^n.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_pc and out_instr come from mem[rd_ptr] when valid. When empty, out_instr = NOP_INSTR and out_pc = 0.
- The cycle's update is chosen in this order:
  - flush=1: rd_ptr, wr_ptr and count go to 0. A simultaneous push and pop are both discarded. Memory contents are don't-care.
  - push only: write mem[wr_ptr], advance wr_ptr, count+1.
  - pop only: advance rd_ptr, count-1.
  - push and pop together: write, advance both pointers, count unchanged. This is legal at any count 1..DEPTH-1. It cannot occur at count=DEPTH because in_ready=0 there, and cannot occur at count=0 because out_valid=0 there.
- in_valid while in_ready=0: no state change. Fetch must hold its data.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush.

## Timing
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Outputs immediately become out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1. Reset takes precedence over flush. Deassertion is sampled at the next clk edge.
- Latency: a pair pushed at edge N into an empty queue is visible on out_* after edge N, with out_valid=1 in cycle N+1. There is no same-cycle fall-through.
- Sustained throughput is 1 pair/cycle when out_ready=1 continuously.
- Stall: with out_ready=0, the head and all outputs hold. The queue fills to DEPTH, then in_ready drops the cycle after the filling push.
- Flush: the queue is empty in the cycle after the flush edge (out_valid=0, NOP on out_instr). in_ready=1 in that same cycle.
- Full with out_ready=1: the pop completes at the edge and in_ready rises in the next cycle, giving one bubble on the input side.

## Test plan
- Reset mid-stream: fill 3 entries, assert reset=0 asynchronously between edges -> out_valid=0, out_instr=32'h0000_0013 and count=0 before the next edge. After release, pushes resume at mem[0].
- Streaming: out_ready=1, push PCs 0x00, 0x04, 0x08, 0x0C back to back -> the same PCs and instructions appear in order one cycle later, count stays at 1, in_ready stays 1.
- Fill/stall (DEPTH=4): out_ready=0, push 6 pairs -> first 4 accepted, in_ready=0 from the cycle after the 4th push, count=4, head holds the first pair. Release out_ready -> pairs drain in order, and pairs 5 and 6 are accepted after in_ready rises.
- Flush with simultaneous push/pop at count=2 -> count=0 next cycle, no output of the pushed pair, in_ready=1.
- Wrap-around with DEPTH=3 (non-power-of-two): 10 push/pop cycles at count oscillating 1..3 -> FIFO order preserved across pointer wraps, count never exceeds 3.
- Empty output: count=0 with out_ready toggling -> out_valid=0, out_instr=NOP_INSTR, no pointer movement.
